rx_detector: RTL and testbench
==============================

RX_DETECTOR -- requirements
Module: rx_detector

Interface
REQ-001 Parameter SPB, default 8, samples per bit, power of two, 2..64.
REQ-002 Parameter SYNC_WORD, default 8'hA5, frame sync pattern, MSB first.
REQ-003 Parameter FRAME_BYTES, default 4, data bytes per frame after sync.
REQ-004 Parameter MARGIN, default 32, weak-decision threshold on |bit sum|.
REQ-005 Port clk  input  1  single clock; all state on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port rx_in  input  9  signed two's-complement sample from the channel model output.
REQ-008 Port rx_en  input  1  rx_in valid this cycle; low stalls all integration state.
REQ-009 Port bit_out  output  1  last decided bit.
REQ-010 Port bit_valid  output  1  one-cycle pulse per decided bit.
REQ-011 Port data_out  output  8  assembled data byte, MSB first.
REQ-012 Port data_valid  output  1  one-cycle pulse per data byte.
REQ-013 Port locked  output  1  high while in LOCKED state.

Function
REQ-014 Integrate-and-dump: signed accumulator, width 9+log2(SPB), no overflow possible; sample counter 0..SPB-1, advancing only when rx_en=1.
REQ-015 On the edge taking the SPB-th enabled sample: sum = acc + rx_in; bit = 1 if sum >= 0 (tie -> 1), else 0; acc and counter clear to 0.
REQ-016 bit_out/bit_valid registered on that edge: visible one cycle after the last sample is presented; bit_valid high exactly one cycle.
REQ-017 rx_en=0: acc, counter, shift register, FSM hold; no pulses generated.
REQ-018 No symbol timing recovery: bit phase fixed by counter starting at 0 after reset.
REQ-019 8-bit shift register takes each decided bit at LSB, shifting left.
REQ-020 FSM states HUNT (reset) and LOCKED.
REQ-021 HUNT: when the shift value including the new bit equals SYNC_WORD, go LOCKED on that edge; locked rises with that bit_valid; byte and bit-in-byte counters clear; no data_valid.
REQ-022 LOCKED: every 8th decided bit loads data_out and pulses data_valid, coincident with that bit's bit_valid; sync compare disabled.
REQ-023 After the FRAME_BYTES-th data_valid, return to HUNT on the same edge; locked falls with that pulse; shift register clears to 0.
REQ-024 data_out holds its value between data_valid pulses.

Reset
REQ-025 reset=1 asynchronously forces: acc=0, counters=0, shift=0, FSM=HUNT, bit_out=0, bit_valid=0, data_out=8'h00, data_valid=0, locked=0.
REQ-026 Reset asserted mid-bit or mid-frame discards partial bit and byte; no pulse is emitted after release until a full SPB samples are taken.

Configuration
REQ-027 Macro RX_ERR_CNT_EN defined: adds output err_cnt (8 bits), incremented when a decided bit has |sum| < MARGIN, saturating at 255, cleared by reset only.
REQ-028 RX_ERR_CNT_EN undefined: err_cnt port and its logic are absent; all other behaviour identical.

Verification
REQ-029 SPB=8, 8 samples of +64 -> bit_valid one cycle after 8th sample, bit_out=1; 8 samples of -64 -> bit_out=0.
REQ-030 Samples +5,-5 alternating (sum 0) -> bit_out=1.
REQ-031 Bits of 8'hA5 then 8'h3C, 8'h00, 8'hFF, 8'h81 at +/-64 with channel noise -> locked rises on 8th sync bit; data_out 3C,00,FF,81 each with one data_valid; locked falls with the 4th.
REQ-032 rx_en low 5 cycles after 3rd sample of a bit -> decision identical to unstalled run, bit_valid delayed 5 cycles.
REQ-033 Reset pulse after 2nd data byte -> all outputs 0, HUNT; next frame received correctly.
REQ-034 RX_ERR_CNT_EN: 10 bits at +/-2 amplitude (|sum|=16) -> err_cnt=10; 300 such bits -> err_cnt=255.

Source files
------------

// File: rtl/rx_detector.sv
`default_nettype none
// ============================================================================
// Module   : rx_detector
// Purpose  : Integrate-and-dump bit detector with sync-word hunt and
//            fixed-length frame byte assembly.
// Options  : RX_ERR_CNT_EN adds an 8-bit saturating weak-decision counter
//            (err_cnt output).
// Revision : 1.0 - initial release
// ============================================================================
module rx_detector #(
  parameter int         SPB         = 8,
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         FRAME_BYTES = 4,
  parameter int         MARGIN      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [8:0] rx_in,
  input  logic              rx_en,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              locked
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CW = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int AW = 9 + CW;
  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(SPB - 1);
  localparam logic [BW-1:0] LAST_BYTE   = BW'(FRAME_BYTES - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q,   state_d;
  logic signed [AW-1:0] acc_q,     acc_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [7:0]           shift_q,   shift_d;
  logic [2:0]           bitcnt_q,  bitcnt_d;
  logic [BW-1:0]        bytecnt_q, bytecnt_d;
  logic                 bit_q,     bit_d;
  logic                 bv_q,      bv_d;
  logic [7:0]           dout_q,    dout_d;
  logic                 dv_q,      dv_d;

  logic signed [AW-1:0] w_sum;
  logic                 w_bit;
  logic [7:0]           w_shift;
  logic                 w_last;

  // Accumulator width covers SPB full-scale samples, so the sum never wraps.
  assign w_sum   = acc_q + $signed({{CW{rx_in[8]}}, rx_in});
  assign w_bit   = ~w_sum[AW-1];
  assign w_shift = {shift_q[6:0], w_bit};
  assign w_last  = rx_en && (cnt_q == LAST_SAMPLE);

  // Next-state: integrate samples, decide bits, run the sync/frame FSM.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    bit_d     = bit_q;
    bv_d      = 1'b0;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    if (rx_en) begin
      if (w_last) begin
        acc_d   = '0;
        cnt_d   = '0;
        bit_d   = w_bit;
        bv_d    = 1'b1;
        shift_d = w_shift;
        case (state_q)
          HUNT: begin
            if (w_shift == SYNC_WORD) begin
              state_d   = LOCKED;
              bitcnt_d  = '0;
              bytecnt_d = '0;
            end
          end
          LOCKED: begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              dout_d = w_shift;
              dv_d   = 1'b1;
              if (bytecnt_q == LAST_BYTE) begin
                state_d   = HUNT;
                shift_d   = '0;
                bytecnt_d = '0;
              end else begin
                bytecnt_d = bytecnt_q + BW'(1);
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end else begin
        acc_d = w_sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      acc_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      bit_q     <= 1'b0;
      bv_q      <= 1'b0;
      dout_q    <= 8'h00;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      bit_q     <= bit_d;
      bv_q      <= bv_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = bv_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign locked     = (state_q == LOCKED);

`ifdef RX_ERR_CNT_EN
  logic [7:0]         err_q;
  logic signed [31:0] w_sum_ext;
  logic               w_weak;

  assign w_sum_ext = {{(32-AW){w_sum[AW-1]}}, w_sum};
  assign w_weak    = (w_sum_ext < MARGIN) && (w_sum_ext > -MARGIN);

  // Count low-confidence decisions, saturating; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 8'h00;
    end else if (w_last && w_weak && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_detector
// Purpose  : Self-checking bench for rx_detector against a queue-based
//            behavioural model, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_detector;

  localparam int         SPB         = 8;
  localparam logic [7:0] SYNC        = 8'hA5;
  localparam int         FRAME_BYTES = 4;
  localparam int         MARGIN      = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [8:0] rx_in;
  logic              rx_en;
  logic              bit_out, bit_valid, data_valid, locked;
  logic [7:0]        data_out;
`ifdef RX_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit go    = 1'b0;

  rx_detector #(
    .SPB(SPB), .SYNC_WORD(SYNC), .FRAME_BYTES(FRAME_BYTES), .MARGIN(MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .rx_en(rx_en),
    .bit_out(bit_out), .bit_valid(bit_valid), .data_out(data_out),
    .data_valid(data_valid), .locked(locked)
`ifdef RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_samples[$];
  int         m_sum;
  logic       m_bit = 1'b0, m_bv = 1'b0, m_dv = 1'b0, m_lock = 1'b0;
  logic [7:0] m_dout = 8'h00, m_win = 8'h00;
  int         m_nbits = 0, m_nbytes = 0, m_err = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_samples.delete();
      m_bit = 0; m_bv = 0; m_dv = 0; m_lock = 0;
      m_dout = 0; m_win = 0; m_nbits = 0; m_nbytes = 0; m_err = 0;
    end else begin
      m_bv = 0;
      m_dv = 0;
      if (rx_en) begin
        m_samples.push_back(int'(rx_in));
        if (m_samples.size() == SPB) begin
          m_sum = m_samples.sum();
          m_samples.delete();
          m_bit = (m_sum >= 0);
          m_bv  = 1;
          if (m_sum < MARGIN && m_sum > -MARGIN && m_err < 255) m_err++;
          m_win = {m_win[6:0], m_bit};
          if (!m_lock) begin
            if (m_win == SYNC) begin
              m_lock = 1; m_nbits = 0; m_nbytes = 0;
            end
          end else begin
            m_nbits++;
            if (m_nbits == 8) begin
              m_nbits = 0;
              m_dout  = m_win;
              m_dv    = 1;
              m_nbytes++;
              if (m_nbytes == FRAME_BYTES) begin
                m_lock = 0;
                m_win  = 8'h00;
              end
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("cyc_bit_valid", int'(bit_valid), int'(m_bv));
      chk("cyc_bit_out", int'(bit_out), int'(m_bit));
      chk("cyc_data_valid", int'(data_valid), int'(m_dv));
      chk("cyc_data_out", int'(data_out), int'(m_dout));
      chk("cyc_locked", int'(locked), int'(m_lock));
`ifdef RX_ERR_CNT_EN
      chk("cyc_err_cnt", int'(err_cnt), m_err);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int s, input logic en);
    rx_in = 9'(s);
    rx_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int amp, input int noise, input int stall_pct);
    for (int i = 0; i < SPB; i++) begin
      while (int'($urandom_range(99)) < stall_pct) step(int'($urandom_range(511)) - 256, 1'b0);
      step((b ? amp : -amp) + int'($urandom_range(2 * noise)) - noise, 1'b1);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int amp, input int noise, input int stall_pct);
    for (int i = 7; i >= 0; i--) send_bit(v[i], amp, noise, stall_pct);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_bit_out", int'(bit_out), 0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_locked", int'(locked), 0);
    step(0, 1'b0);
    step(0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic frame_chk(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3, input int stall_pct);
    logic [7:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    send_byte(SYNC, 64, 20, stall_pct);
    chk("sync_locked", int'(locked), 1);
    chk("sync_no_dv", int'(data_valid), 0);
    for (int k = 0; k < 4; k++) begin
      send_byte(d[k], 64, 20, stall_pct);
      chk("frame_dv", int'(data_valid), 1);
      chk("frame_data", int'(data_out), int'(d[k]));
      chk("frame_locked", int'(locked), (k == 3) ? 0 : 1);
    end
  endtask

  int stall_seq[8] = '{-20, 5, -7, 3, -9, 1, -2, 4};

  initial begin
    reset = 1'b1;
    rx_in = '0;
    rx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    go = 1'b1;
    chk("init_bit_out", int'(bit_out), 0);
    chk("init_bit_valid", int'(bit_valid), 0);
    chk("init_data_out", int'(data_out), 0);
    chk("init_data_valid", int'(data_valid), 0);
    chk("init_locked", int'(locked), 0);
    reset = 1'b0;

    // Strong one, then strong zero.
    for (int i = 0; i < 8; i++) begin
      step(64, 1'b1);
      if (i == 6) chk("pos_pre_bv", int'(bit_valid), 0);
    end
    chk("pos_bv", int'(bit_valid), 1);
    chk("pos_bit", int'(bit_out), 1);
    for (int i = 0; i < 8; i++) step(-64, 1'b1);
    chk("neg_bv", int'(bit_valid), 1);
    chk("neg_bit", int'(bit_out), 0);
    step(0, 1'b0);
    chk("idle_bv", int'(bit_valid), 0);
    chk("idle_bit_hold", int'(bit_out), 0);

    // Zero-sum tie decides one.
    for (int i = 0; i < 8; i++) step((i % 2 == 1) ? -5 : 5, 1'b1);
    chk("tie_bv", int'(bit_valid), 1);
    chk("tie_bit", int'(bit_out), 1);

    // Unstalled reference (sum -25 -> 0), then the same samples with a 5-cycle stall.
    for (int i = 0; i < 8; i++) step(stall_seq[i], 1'b1);
    chk("nostall_bit", int'(bit_out), 0);
    for (int i = 0; i < 13; i++) begin
      if (i >= 3 && i < 8) step(200, 1'b0);
      else step(stall_seq[(i < 3) ? i : i - 5], 1'b1);
      if (i == 11) chk("stall_pre_bv", int'(bit_valid), 0);
    end
    chk("stall_bv", int'(bit_valid), 1);
    chk("stall_bit", int'(bit_out), 0);

    // Full frame with channel noise.
    do_reset();
    frame_chk(8'h3C, 8'h00, 8'hFF, 8'h81, 0);

    // Reset after the second data byte, then a partial bit, then a clean frame.
    do_reset();
    send_byte(SYNC, 64, 20, 10);
    send_byte(8'h3C, 64, 20, 10);
    send_byte(8'h00, 64, 20, 10);
    chk("mid_locked", int'(locked), 1);
    send_bit(1'b1, 64, 0, 0);
    step(64, 1'b1);
    step(64, 1'b1);
    step(64, 1'b1);
    do_reset();
    frame_chk(8'h5A, 8'hC3, 8'h12, 8'hE7, 15);

    // Randomised traffic: stray bytes, frames, stalls and mid-stream resets.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3))
        0: send_byte(8'($urandom), 40 + int'($urandom_range(60)), 30, 20);
        1: begin
          send_byte(SYNC, 64, 30, 20);
          for (int k = 0; k < FRAME_BYTES; k++) send_byte(8'($urandom), 64, 30, 20);
        end
        2: begin
          for (int k = 0; k < int'($urandom_range(20)); k++)
            step(int'($urandom_range(511)) - 256, 1'($urandom_range(1)));
        end
        default: begin
          for (int k = 0; k < int'($urandom_range(12)); k++) step(64, 1'b1);
          do_reset();
        end
      endcase
    end

    // Weak decisions for the error counter.
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 2, 0, 0);
`ifdef RX_ERR_CNT_EN
    chk("err_ten", int'(err_cnt), 10);
`endif
    for (int i = 0; i < 290; i++) send_bit(1'($urandom), 2, 0, 0);
`ifdef RX_ERR_CNT_EN
    chk("err_sat", int'(err_cnt), 255);
`endif

    step(0, 1'b0);
    step(0, 1'b0);
    go = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
